// File: rtl/phit_pkg.sv
// Shared phit format, FIFO entry layout and injector FSM states.
// Used by phit_fifo and phit_injector.
package phit_pkg;

  localparam int PHIT_W  = 18;
  localparam int ROUTE_W = 6;
  localparam int DATA_W  = 10;

  localparam logic [1:0] PHIT_IDLE = 2'b00;
  localparam logic [1:0] PHIT_HEAD = 2'b01;
  localparam logic [1:0] PHIT_BODY = 2'b10;
  localparam logic [1:0] PHIT_TAIL = 2'b11;

  localparam int TYPE_LSB  = 16;
  localparam int ROUTE_LSB = 10;
  localparam int DATA_LSB  = 0;

  typedef struct packed {
    logic [1:0]         typ;
    logic [ROUTE_W-1:0] route;
    logic [DATA_W-1:0]  data;
  } phit_t;

  typedef struct packed {
    logic               last;
    logic [ROUTE_W-1:0] route;
    logic [DATA_W-1:0]  data;
  } entry_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEAD,
    ST_BODY
  } state_e;

  function automatic phit_t mk_phit(
    input logic [1:0]         t,
    input logic [ROUTE_W-1:0] r,
    input logic [DATA_W-1:0]  d
  );
    logic [PHIT_W-1:0] p;
    p = (PHIT_W'(t) << TYPE_LSB)
      | (PHIT_W'(r) << ROUTE_LSB)
      | (PHIT_W'(d) << DATA_LSB);
    return phit_t'(p);
  endfunction

endpackage

// File: rtl/phit_fifo.sv
// Word FIFO of {last, route, data} entries for the phit injector.
// Pointers carry one wrap bit to tell full from empty.
module phit_fifo
  import phit_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic   i_clk,
  input  logic   i_rst_n,
  input  logic   i_wr,
  input  entry_t i_wdata,
  input  logic   i_rd,
  output entry_t o_rdata,
  output logic   o_full,
  output logic   o_empty
);

  localparam int AW = $clog2(DEPTH);

  entry_t mem [DEPTH];

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        wr_en;
  logic        rd_en;

  assign o_empty = (wr_ptr == rd_ptr);
  assign o_full  = (wr_ptr[AW] != rd_ptr[AW])
                && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign wr_en = i_wr & ~o_full;
  assign rd_en = i_rd & ~o_empty;

  assign o_rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/phit_injector.sv
// Store-and-forward packet injector emitting gap-free phit bursts.
// Optional stats counters: define PHIT_INJECTOR_STATS_EN.
module phit_injector
  import phit_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [DATA_W-1:0]  i_data,
  input  logic [ROUTE_W-1:0] i_route,
  input  logic               i_last,
`ifdef PHIT_INJECTOR_STATS_EN
  output logic [15:0]        o_pkt_sent,
  output logic [15:0]        o_words_sent,
`endif
  output logic [PHIT_W-1:0]  o_phit
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic               full;
  logic               empty;
  logic               wr;
  logic               pop;
  logic               inc;
  logic               dec;
  logic               first_q;
  logic [ROUTE_W-1:0] route_q;
  logic [CW-1:0]      cnt_q;
  logic [CW-1:0]      cnt_d;
  entry_t             wentry;
  entry_t             front;
  state_e             state_q;
  state_e             state_d;
  phit_t              phit_q;
  phit_t              phit_d;

  assign o_ready = i_rst_n & ~full;
  assign wr      = i_valid & o_ready;
  assign inc     = wr & i_last;
  assign o_phit  = phit_q;

  // Route is only sampled on a first word; later words reuse it.
  assign wentry.last  = i_last;
  assign wentry.route = first_q ? i_route : route_q;
  assign wentry.data  = i_data;

  phit_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_wr    (wr),
    .i_wdata (wentry),
    .i_rd    (pop),
    .o_rdata (front),
    .o_full  (full),
    .o_empty (empty)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      first_q <= 1'b1;
      route_q <= '0;
    end else if (wr) begin
      first_q <= i_last;
      if (first_q) begin
        route_q <= i_route;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    phit_d  = '0;
    pop     = 1'b0;
    dec     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cnt_q != '0) begin
          phit_d  = mk_phit(PHIT_HEAD, front.route, '0);
          state_d = ST_BODY;
        end
      end
      ST_HEAD: begin
        phit_d  = mk_phit(PHIT_HEAD, front.route, '0);
        state_d = ST_BODY;
      end
      ST_BODY: begin
        pop = ~empty;
        if (front.last) begin
          dec    = 1'b1;
          phit_d = mk_phit(PHIT_TAIL, '0, front.data);
          // Another packet is ready if one remains or completes now.
          if ((cnt_q > CW'(1)) || inc) begin
            state_d = ST_HEAD;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          phit_d = mk_phit(PHIT_BODY, '0, front.data);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    unique case (1'b1)
      (inc & ~dec): cnt_d = cnt_q + 1'b1;
      (dec & ~inc): cnt_d = cnt_q - 1'b1;
      default:      cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      phit_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      phit_q  <= phit_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef PHIT_INJECTOR_STATS_EN
  logic [15:0] pkt_q;
  logic [15:0] words_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pkt_q   <= '0;
      words_q <= '0;
    end else begin
      if (dec) begin
        pkt_q <= pkt_q + 1'b1;
      end
      if (pop) begin
        words_q <= words_q + 1'b1;
      end
    end
  end

  assign o_pkt_sent   = pkt_q;
  assign o_words_sent = words_q;
`endif

endmodule

// File: tb/tb_phit_injector.sv
// Directed, table-driven bench for phit_injector.
// Stats checks compile in when PHIT_INJECTOR_STATS_EN is defined.
module tb_phit_injector;

  localparam int DEPTH = 16;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [9:0]  i_data;
  logic [5:0]  i_route;
  logic        i_last;
  logic [17:0] o_phit;
`ifdef PHIT_INJECTOR_STATS_EN
  logic [15:0] o_pkt_sent;
  logic [15:0] o_words_sent;
`endif

  phit_injector #(
    .DEPTH (DEPTH)
  ) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_data       (i_data),
    .i_route      (i_route),
    .i_last       (i_last),
`ifdef PHIT_INJECTOR_STATS_EN
    .o_pkt_sent   (o_pkt_sent),
    .o_words_sent (o_words_sent),
`endif
    .o_phit       (o_phit)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  logic [17:0] log_q[$];
  bit          log_en = 1'b0;

  always @(negedge i_clk) begin
    if (log_en) log_q.push_back(o_phit);
  end

  // Flags client-contract violations: packets longer than DEPTH words.
  int pkt_words;
  int bad_len;
  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pkt_words = 0;
    end else if (i_valid && o_ready) begin
      if (pkt_words + 1 > DEPTH) begin
        bad_len = bad_len + 1;
        $display("FAIL pkt_len: got %0d words, limit %0d",
                 pkt_words + 1, DEPTH);
      end
      pkt_words = i_last ? 0 : pkt_words + 1;
    end
  end
  initial bad_len = 0;

  typedef struct {
    string       name;
    logic [5:0]  route;
    int          len;
    logic [9:0]  d[4];
    logic [17:0] e[5];
  } vec_t;

  task automatic chk(input string nm, input logic [17:0] act,
                     input logic [17:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_i(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic send_word(input logic [5:0] r, input logic [9:0] d,
                           input logic l);
    int g = 0;
    @(negedge i_clk);
    i_valid = 1'b1;
    i_route = r;
    i_data  = d;
    i_last  = l;
    while (!o_ready && g < 200) begin
      @(negedge i_clk);
      g++;
    end
    if (g >= 200) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: ready got 0 expected 1");
    end
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic log_start();
    @(posedge i_clk);
    #1;
    log_q.delete();
    log_en = 1'b1;
  endtask

  task automatic check_log(input string nm, input logic [17:0] exp[$],
                           input int want);
    int idx = -1;
    log_en = 1'b0;
    foreach (log_q[i]) if (idx < 0 && log_q[i] != 18'h0) idx = i;
    if (idx < 0) begin
      checks++;
      errors++;
      $display("FAIL %s_start: got no phit expected head at slot %0d",
               nm, want);
      return;
    end
    if (want >= 0) chk_i({nm, "_lat"}, idx, want);
    foreach (exp[k]) begin
      if (idx + k < log_q.size()) begin
        chk($sformatf("%s_ph%0d", nm, k), log_q[idx + k], exp[k]);
      end else begin
        checks++;
        errors++;
        $display("FAIL %s_ph%0d: got nothing expected %h", nm, k, exp[k]);
      end
    end
    if (idx + exp.size() < log_q.size())
      chk({nm, "_end"}, log_q[idx + exp.size()], 18'h0);
  endtask

  vec_t        tbl[5];
  logic [17:0] eq[$];
  int          nz;

  initial begin
    tbl[0] = '{"v1w", 6'b10_01_11, 1, '{10'h155, 10'h0, 10'h0, 10'h0},
               '{18'h19C00, 18'h30155, 18'h0, 18'h0, 18'h0}};
    tbl[1] = '{"v3w", 6'b00_01_10, 3, '{10'h001, 10'h002, 10'h003, 10'h0},
               '{18'h11800, 18'h20001, 18'h20002, 18'h30003, 18'h0}};
    tbl[2] = '{"v2w", 6'b11_11_11, 2, '{10'h3FF, 10'h000, 10'h0, 10'h0},
               '{18'h1FC00, 18'h203FF, 18'h30000, 18'h0, 18'h0}};
    tbl[3] = '{"v4w", 6'b00_00_00, 4, '{10'h0AA, 10'h155, 10'h2AA, 10'h001},
               '{18'h10000, 18'h200AA, 18'h20155, 18'h202AA, 18'h30001}};
    tbl[4] = '{"v1b", 6'b01_00_10, 1, '{10'h3FF, 10'h0, 10'h0, 10'h0},
               '{18'h14800, 18'h303FF, 18'h0, 18'h0, 18'h0}};

    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_data  = '0;
    i_route = '0;
    i_last  = 1'b0;
    #1;
    chk("rst_phit", o_phit, 18'h0);
    chk("rst_ready", {17'h0, o_ready}, 18'h0);
`ifdef PHIT_INJECTOR_STATS_EN
    chk("rst_pkts", {2'b0, o_pkt_sent}, 18'h0);
    chk("rst_words", {2'b0, o_words_sent}, 18'h0);
`endif
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("post_rst_ready", {17'h0, o_ready}, 18'h1);
    chk("post_rst_phit", o_phit, 18'h0);

    for (int v = 0; v < 5; v++) begin
      log_start();
      for (int w = 0; w < tbl[v].len; w++)
        send_word(tbl[v].route, tbl[v].d[w], w == tbl[v].len - 1);
      repeat (tbl[v].len + 4) @(negedge i_clk);
      eq.delete();
      for (int k = 0; k <= tbl[v].len; k++) eq.push_back(tbl[v].e[k]);
      check_log(tbl[v].name, eq, tbl[v].len + 1);
    end

    // Two 2-word packets back-to-back: six phits with no gap.
    log_start();
    send_word(6'b01_00_00, 10'h011, 1'b0);
    send_word(6'b01_00_00, 10'h012, 1'b1);
    send_word(6'b00_11_00, 10'h021, 1'b0);
    send_word(6'b00_11_00, 10'h022, 1'b1);
    repeat (10) @(negedge i_clk);
    eq = '{18'h14000, 18'h20011, 18'h30012,
           18'h13000, 18'h20021, 18'h30022};
    check_log("b2b", eq, 3);

    // Full FIFO: 16-word packet, output frozen until the last word.
    log_start();
    for (int w = 0; w < DEPTH; w++)
      send_word(6'b10_10_10, 10'(10'h100 + w), w == DEPTH - 1);
    @(negedge i_clk);
    chk("full_ready0", {17'h0, o_ready}, 18'h0);
    @(negedge i_clk);
    chk("full_head", o_phit, 18'h1A800);
    chk("full_ready1", {17'h0, o_ready}, 18'h0);
    @(negedge i_clk);
    chk("full_ready2", {17'h0, o_ready}, 18'h1);
    repeat (20) @(negedge i_clk);
    eq.delete();
    eq.push_back(18'h1A800);
    for (int w = 0; w < DEPTH - 1; w++) eq.push_back(18'(18'h20100 + w));
    eq.push_back(18'h3010F);
    check_log("full", eq, DEPTH + 1);

    // Reset during the second body phit of a 3-word packet.
    send_word(6'b00_01_10, 10'h001, 1'b0);
    send_word(6'b00_01_10, 10'h002, 1'b0);
    send_word(6'b00_01_10, 10'h003, 1'b1);
    repeat (4) @(negedge i_clk);
    chk("mid_body2", o_phit, 18'h20002);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("mid_rst_phit", o_phit, 18'h0);
    chk("mid_rst_ready", {17'h0, o_ready}, 18'h0);
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    log_start();
    repeat (6) @(negedge i_clk);
    log_en = 1'b0;
    nz = 0;
    foreach (log_q[i]) if (log_q[i] != 18'h0) nz++;
    chk_i("no_remnant", nz, 0);
    chk("rel_ready", {17'h0, o_ready}, 18'h1);
    log_start();
    send_word(6'b01_00_10, 10'h3FF, 1'b1);
    repeat (6) @(negedge i_clk);
    eq = '{18'h14800, 18'h303FF};
    check_log("after_rst", eq, 2);

`ifdef PHIT_INJECTOR_STATS_EN
    chk("stat_pkts", {2'b0, o_pkt_sent}, 18'h1);
    chk("stat_words", {2'b0, o_words_sent}, 18'h1);
`endif

    errors = errors + bad_len;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
